// File: rtl/core_axi_rd_arbiter.sv
// Round-robin arbiter sharing the AR/R read channels of the core AXI4 master
// among NUM_REQ internal read requesters. One burst in flight at a time; the
// grant is held from AR acceptance to the final accepted R beat. Beats are
// counted and any rlast / burst-length mismatch raises a sticky len_err.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no burst owned; pick a round-robin winner and ack its AR
// ST_ADDR   | present the latched address/length on the core AR channel
// ST_DATA   | route core R beats to the granted requester until rlast
module core_axi_rd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_arvalid,
   output logic [NUM_REQ-1:0]            req_arready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
   input  logic [NUM_REQ*8-1:0]          req_arlen,
   output logic [NUM_REQ-1:0]            req_rvalid,
   input  logic [NUM_REQ-1:0]            req_rready,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic [1:0]                    req_rresp,
   output logic                          req_rlast,
   output logic                          m_axi_core_arvalid,
   input  logic                          m_axi_core_arready,
   output logic [ADDR_WIDTH-1:0]         m_axi_core_araddr,
   output logic [7:0]                    m_axi_core_arlen,
   input  logic                          m_axi_core_rvalid,
   output logic                          m_axi_core_rready,
   input  logic [DATA_WIDTH-1:0]         m_axi_core_rdata,
   input  logic [1:0]                    m_axi_core_rresp,
   input  logic                          m_axi_core_rlast,
   output logic                          busy,
   output logic [ID_W-1:0]               grant_id,
   output logic                          len_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [ID_W-1:0]         last_grant;
   logic [ID_W-1:0]         winner;
   logic                    win_vld;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [7:0]              win_len;
   int                      best_dist;
   logic [8:0]              beat_cnt;
   logic                    beat_acc;

   // Priority distance of requester i from the slot after the last grant.
   function automatic int rr_dist(input int i, input logic [ID_W-1:0] lg);
      return (i + NUM_REQ - 1 - int'(lg)) % NUM_REQ;
   endfunction

   // Round-robin winner: the pending requester nearest after last_grant.
   always_comb begin
      winner    = '0;
      win_vld   = 1'b0;
      win_addr  = '0;
      win_len   = '0;
      best_dist = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_arvalid[i] && (rr_dist(i, last_grant) < best_dist)) begin
            best_dist = rr_dist(i, last_grant);
            winner    = ID_W'(i);
            win_vld   = 1'b1;
            win_addr  = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_len   = req_arlen[i*8 +: 8];
         end
      end
   end

   assign beat_acc = (state == ST_DATA) && m_axi_core_rvalid && m_axi_core_rready;

   // Next state and the per-requester handshake steering.
   always_comb begin
      state_nx          = state;
      req_arready       = '0;
      req_rvalid        = '0;
      m_axi_core_rready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (win_vld) begin
               req_arready[winner] = 1'b1;
               state_nx            = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (m_axi_core_arready) begin
               state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            req_rvalid[grant_id] = m_axi_core_rvalid;
            m_axi_core_rready    = req_rready[grant_id];
            if (m_axi_core_rvalid && req_rready[grant_id] && m_axi_core_rlast) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // R payload is broadcast straight through; only valid/ready are steered.
   assign req_rdata = m_axi_core_rdata;
   assign req_rresp = m_axi_core_rresp;
   assign req_rlast = m_axi_core_rlast;

   // State, grant bookkeeping, latched AR request and beat/length checking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         last_grant         <= ID_W'(NUM_REQ - 1);
         grant_id           <= '0;
         beat_cnt           <= '0;
         busy               <= 1'b0;
         len_err            <= 1'b0;
         m_axi_core_arvalid <= 1'b0;
         m_axi_core_araddr  <= '0;
         m_axi_core_arlen   <= '0;
      end else begin
         state              <= state_nx;
         busy               <= (state_nx != ST_IDLE);
         m_axi_core_arvalid <= (state_nx == ST_ADDR);
         if ((state == ST_IDLE) && win_vld) begin
            grant_id          <= winner;
            m_axi_core_araddr <= win_addr;
            m_axi_core_arlen  <= win_len;
            beat_cnt          <= '0;
         end
         if (beat_acc) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (m_axi_core_rlast) begin
               last_grant <= grant_id;
               if (beat_cnt != {1'b0, m_axi_core_arlen}) begin
                  len_err <= 1'b1;
               end
            end else if (beat_cnt == {1'b0, m_axi_core_arlen}) begin
               // burst overran its length; keep routing until rlast shows up
               len_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// Bench for core_axi_rd_arbiter: queue-driven requesters, a core R responder
// and a transaction-level round-robin model feeding a scoreboard monitor.
`timescale 1ns/1ps
module tb_core_axi_rd_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 512;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
   logic [N*AW-1:0] req_araddr;
   logic [N*8-1:0]  req_arlen;
   logic [DW-1:0]   req_rdata, m_rdata;
   logic [1:0]      req_rresp, m_rresp;
   logic            req_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [AW-1:0]   m_araddr;
   logic [7:0]      m_arlen;
   logic            busy, len_err;
   logic [IW-1:0]   grant_id;

   always #5 clk = ~clk;

   core_axi_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_arvalid(req_arvalid), .req_arready(req_arready),
      .req_araddr(req_araddr), .req_arlen(req_arlen),
      .req_rvalid(req_rvalid), .req_rready(req_rready),
      .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
      .m_axi_core_arvalid(m_arvalid), .m_axi_core_arready(m_arready),
      .m_axi_core_araddr(m_araddr), .m_axi_core_arlen(m_arlen),
      .m_axi_core_rvalid(m_rvalid), .m_axi_core_rready(m_rready),
      .m_axi_core_rdata(m_rdata), .m_axi_core_rresp(m_rresp), .m_axi_core_rlast(m_rlast),
      .busy(busy), .grant_id(grant_id), .len_err(len_err)
   );

   typedef struct { logic [AW-1:0] addr; logic [7:0] len; int nbeats; } req_t;
   typedef struct { int id; logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;

   req_t  pend_q [N][$];
   beat_t core_q [$];
   beat_t exp_r_q[$];
   int    grant_log[$];

   int checks = 0;
   int errors = 0;

   // handshake observations handed from the monitor to the driver
   logic [N-1:0] req_hs_f = '0;
   logic         core_r_acc_f = 1'b0;

   // stimulus modes
   int rr_mode = 2;       // 0 random, 1 toggle, 2 always ready
   bit ar_rand = 0, ar_stall = 0, rv_rand = 0, resp_rand = 0, tog = 0;

   // reference model: 0 idle, 1 address phase, 2 data phase
   int   m_state = 0, m_last = N - 1, m_gid = 0, m_beat = 0, beats_seen = 0;
   logic m_err = 1'b0;
   req_t m_cur;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pend_total();
      int t = 0;
      for (int i = 0; i < N; i++) t += pend_q[i].size();
      return t;
   endfunction

   // Requester and core-slave driver, updated just after each rising edge.
   initial begin
      req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
      forever begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++)
            if (req_hs_f[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
         req_hs_f = '0;
         if (core_r_acc_f && core_q.size() > 0) void'(core_q.pop_front());
         core_r_acc_f = 1'b0;
         tog = ~tog;
         for (int i = 0; i < N; i++) begin
            req_arvalid[i] = (pend_q[i].size() > 0);
            if (pend_q[i].size() > 0) begin
               req_araddr[i*AW +: AW] = pend_q[i][0].addr;
               req_arlen[i*8 +: 8]    = pend_q[i][0].len;
            end
         end
         case (rr_mode)
            0:       req_rready = N'($urandom);
            1:       req_rready = {N{tog}};
            default: req_rready = '1;
         endcase
         m_arready = ar_stall ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
         if (core_q.size() > 0) begin
            m_rvalid = rv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_rdata  = core_q[0].data;
            m_rresp  = core_q[0].resp;
            m_rlast  = core_q[0].last;
         end else begin
            // stray beats with no burst outstanding must never be accepted
            m_rvalid = ($urandom_range(0, 3) == 0);
            m_rdata  = {16{$urandom}};
            m_rresp  = 2'($urandom);
            m_rlast  = 1'($urandom);
         end
      end
   end

   // Monitor: per-cycle protocol checks against the model, beat scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            logic [N-1:0] exp_ardy;
            logic [N-1:0] one;
            int w;
            one = 1;
            exp_ardy = '0;
            w = -1;
            if (m_state == 0) begin
               for (int k = 1; k <= N; k++)
                  if (w < 0 && req_arvalid[(m_last + k) % N]) w = (m_last + k) % N;
               if (w >= 0) exp_ardy = one << w;
            end
            chk("req_arready", req_arready, exp_ardy);
            chk("busy", busy, m_state != 0);
            chk("m_arvalid", m_arvalid, m_state == 1);
            chk("grant_id", grant_id, m_gid);
            chk("len_err", len_err, m_err);
            if (m_state == 1) begin
               chk("m_araddr", m_araddr, m_cur.addr);
               chk("m_arlen", m_arlen, m_cur.len);
            end
            if (m_state == 2) begin
               chk("m_rready", m_rready, req_rready[m_gid]);
               chk("req_rvalid", req_rvalid, m_rvalid ? (one << m_gid) : '0);
            end else begin
               chk("m_rready_idle", m_rready, 1'b0);
               chk("req_rvalid_idle", req_rvalid, '0);
            end
            if ((req_rvalid & req_rready) != '0) begin
               beats_seen++;
               if (exp_r_q.size() == 0) begin
                  chk("unexpected_beat", req_rvalid & req_rready, '0);
               end else begin
                  beat_t e;
                  e = exp_r_q.pop_front();
                  chk("beat_owner", req_rvalid, one << e.id);
                  chk("rdata", req_rdata, e.data);
                  chk("rresp", req_rresp, e.resp);
                  chk("rlast", req_rlast, e.last);
               end
            end
            req_hs_f     = req_arvalid & req_arready;
            core_r_acc_f = m_rvalid & m_rready;
            if (m_state == 0 && w >= 0 && pend_q[w].size() > 0) begin
               m_gid   = w;
               m_cur   = pend_q[w][0];
               grant_log.push_back(w);
               m_state = 1;
            end else if (m_state == 1 && m_arready) begin
               for (int b = 0; b < m_cur.nbeats; b++) begin
                  beat_t nb;
                  nb.id   = m_gid;
                  nb.data = {16{$urandom}};
                  nb.resp = resp_rand ? 2'($urandom) : 2'b00;
                  nb.last = (b == m_cur.nbeats - 1);
                  core_q.push_back(nb);
                  exp_r_q.push_back(nb);
               end
               m_beat  = 0;
               m_state = 2;
            end else if (m_state == 2 && m_rvalid && req_rready[m_gid]) begin
               if (m_rlast) begin
                  if (m_beat != int'(m_cur.len)) m_err = 1'b1;
                  m_last  = m_gid;
                  m_state = 0;
               end else if (m_beat == int'(m_cur.len)) begin
                  m_err = 1'b1;
               end
               m_beat++;
            end
         end
      end
   end

   task automatic push_req(input int r, input logic [AW-1:0] a, input logic [7:0] l, input int nb);
      req_t q;
      q.addr = a; q.len = l; q.nbeats = nb;
      pend_q[r].push_back(q);
   endtask

   task automatic sync_in();
      @(negedge clk); #2;
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int c;
      bit done;
      c = 0; done = 0;
      while (!done && c < budget) begin
         sync_in();
         c++;
         done = (m_state == 0) && (core_q.size() == 0) && (pend_total() == 0);
      end
      chk({nm, "_drain"}, done, 1'b1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_arvalid"}, m_arvalid, 1'b0);
      chk({nm, "_araddr"}, m_araddr, '0);
      chk({nm, "_arlen"}, m_arlen, '0);
      chk({nm, "_grant_id"}, grant_id, '0);
      chk({nm, "_len_err"}, len_err, 1'b0);
      chk({nm, "_arready"}, req_arready, '0);
      chk({nm, "_rready"}, m_rready, 1'b0);
      chk({nm, "_rvalid"}, req_rvalid, '0);
   endtask

   initial begin
      int c;
      #12;
      chk_reset_vals("reset");
      @(posedge clk); #3 rst_n = 1'b1;

      // fairness: everyone pending, expected order 0,1,2,3,0,1,2,3
      sync_in();
      grant_log.delete();
      for (int r = 0; r < N; r++) begin
         push_req(r, 32'h100 * (r + 1), 8'd0, 1);
         push_req(r, 32'h100 * (r + 1) + 32'h40, 8'd0, 1);
      end
      wait_drain("fair", 400);
      chk("fair_count", grant_log.size(), 2 * N);
      for (int k = 0; k < grant_log.size() && k < 2 * N; k++)
         chk($sformatf("fair_order%0d", k), grant_log[k], k % N);

      // single request from requester 2
      sync_in();
      beats_seen = 0;
      push_req(2, 32'h1000, 8'd3, 4);
      wait_drain("single", 200);
      chk("single_beats", beats_seen, 4);
      chk("single_gid", grant_id, 2);

      // backpressure: ready toggles through an 8-beat burst
      rr_mode = 1;
      sync_in();
      beats_seen = 0;
      push_req(1, 32'h2000, 8'd7, 8);
      wait_drain("bp", 300);
      chk("bp_beats", beats_seen, 8);
      rr_mode = 2;

      // address-phase stall with a competing request arriving meanwhile
      ar_stall = 1;
      sync_in();
      grant_log.delete();
      push_req(0, 32'h3000, 8'd1, 2);
      c = 0;
      while (!m_arvalid && c < 50) begin sync_in(); c++; end
      chk("stall_arvalid", m_arvalid, 1'b1);
      push_req(3, 32'h3800, 8'd0, 1);
      repeat (10) sync_in();
      ar_stall = 0;
      wait_drain("stall", 300);
      chk("stall_order0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      chk("stall_order1", grant_log.size() > 1 ? grant_log[1] : -1, 3);

      // randomized traffic
      ar_rand = 1; rv_rand = 1; resp_rand = 1; rr_mode = 0;
      for (int b = 0; b < 40; b++) begin
         int l;
         sync_in();
         l = $urandom_range(0, 7);
         push_req($urandom_range(0, N - 1), $urandom & 32'hFFFF_FFC0, 8'(l), l + 1);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_drain("random", 20000);

      // short burst: arlen 3, rlast on beat 2, then good bursts
      sync_in();
      push_req(1, 32'h4000, 8'd3, 2);
      push_req(2, 32'h4100, 8'd2, 3);
      push_req(0, 32'h4200, 8'd1, 2);
      wait_drain("short", 2000);
      chk("short_len_err", len_err, 1'b1);
      ar_rand = 0; rv_rand = 0; resp_rand = 0; rr_mode = 2;

      // reset while beat 2 of 4 is on the bus
      sync_in();
      push_req(3, 32'h5000, 8'd3, 4);
      c = 0;
      while (!(m_state == 2 && m_beat == 2) && c < 200) begin sync_in(); c++; end
      chk("mid_reach_beat2", m_state == 2 && m_beat == 2, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      for (int i = 0; i < N; i++) pend_q[i].delete();
      core_q.delete(); exp_r_q.delete();
      req_hs_f = '0; core_r_acc_f = 1'b0;
      m_state = 0; m_last = N - 1; m_gid = 0; m_beat = 0; m_err = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      sync_in();
      grant_log.delete();
      for (int r = N - 1; r >= 0; r--) push_req(r, 32'h6000 + 32'h40 * r, 8'd1, 2);
      wait_drain("postrst", 400);
      chk("postrst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

      // overlong burst: arlen 1 but three beats before rlast
      sync_in();
      beats_seen = 0;
      push_req(2, 32'h7000, 8'd1, 3);
      wait_drain("long", 200);
      chk("long_beats", beats_seen, 3);
      chk("long_len_err", len_err, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_axi_rd_arbiter.md
# core_axi_rd_arbiter

Round-robin arbiter that shares the read channels (AR/R) of the `m_axi_core` AXI4 master among `NUM_REQ` internal read requesters, such as the weight, activation and instruction loaders. It sits between those loaders and the core read port of `top`. Exactly one burst is in flight at a time. The grant is held from AR acceptance until the burst's final R beat is accepted. The block also counts beats and flags any mismatch between `rlast` and the expected burst length.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 512, AXI data width
- `ID_W`, `$clog2(NUM_REQ)`, grant index width (derived, do not override)

Ports:
- `clk`  in  1  clock; one clock for the whole block
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_arvalid`  in  NUM_REQ  per-requester AR valid
- `req_arready`  out  NUM_REQ  per-requester AR ready (one-hot or zero)
- `req_araddr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i
- `req_arlen`  in  NUM_REQ*8  packed burst lengths, AXI encoding (beats-1)
- `req_rvalid`  out  NUM_REQ  per-requester R valid
- `req_rready`  in  NUM_REQ  per-requester R ready
- `req_rdata`  out  DATA_WIDTH  R data, broadcast to all requesters
- `req_rresp`  out  2  R response, broadcast
- `req_rlast`  out  1  R last, broadcast
- `m_axi_core_arvalid` / `m_axi_core_arready`  out/in  1  core AR handshake
- `m_axi_core_araddr`  out  ADDR_WIDTH  core AR address
- `m_axi_core_arlen`  out  8  core AR length
- `m_axi_core_rvalid` / `m_axi_core_rready`  in/out  1  core R handshake
- `m_axi_core_rdata` / `m_axi_core_rresp` / `m_axi_core_rlast`  in  DATA_WIDTH / 2 / 1  core R payload
- `busy`  out  1  high in ADDR or DATA state
- `grant_id`  out  ID_W  index of the current or last granted requester
- `len_err`  out  1  sticky; set on a burst-length mismatch; cleared only by reset

## Operation
State machine with three states: IDLE, ADDR, DATA.

IDLE:
- If any `req_arvalid` bit is set, select winner w by round-robin. The search starts at `(last_grant+1) mod NUM_REQ`, where `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority.
- Assert `req_arready[w]` combinationally in that same cycle.
- Latch `req_araddr[w]` and `req_arlen[w]`, latch `grant_id <= w`, clear the beat counter, go to ADDR.
- `req_arready` is all-zero in every other state and in IDLE when no request is pending.

ADDR:
- Drive `m_axi_core_arvalid=1` with the latched address and length. Address and length are stable until the handshake.
- On `m_axi_core_arready`, go to DATA.

DATA:
- `req_rvalid[grant_id] = m_axi_core_rvalid`; all other `req_rvalid` bits are 0.
- `m_axi_core_rready = req_rready[grant_id]`.
- Data, resp and last pass through combinationally, no buffering.
- Each accepted beat increments the 9-bit beat counter.
- When `m_axi_core_rlast` is accepted: set `last_grant <= grant_id` and go to IDLE.
- `len_err` is set on either mismatch:
  - `rlast` arrives while `counter != arlen`;
  - the counter equals `arlen` on an accepted beat without `rlast`. In this case stay in DATA until `rlast`.
- An `rresp` other than OKAY is passed through unchanged and does not affect state.

Other rules:
- `m_axi_core_rready` is 0 outside DATA. R beats arriving outside DATA are not accepted.
- Requests that are not granted keep `arvalid` asserted. The arbiter never drops them, and each waits at most NUM_REQ-1 bursts.

## Timing
Reset values (asynchronous assert, synchronous release):
- state IDLE, `last_grant = NUM_REQ-1`, `grant_id = 0`, counter 0
- `busy`, `len_err`, `m_axi_core_arvalid` = 0
- `m_axi_core_araddr` and `m_axi_core_arlen` = 0

Latency:
- Requester AR handshake in cycle T gives `m_axi_core_arvalid` high in cycle T+1.
- Core AR handshake in cycle T makes DATA active in T+1; the first beat can be accepted in T+1.
- `rlast` accepted in cycle T puts the block in IDLE at T+1, where the next grant can be issued. The gap between bursts is therefore 1 cycle.

`busy` is registered from the state: high in ADDR and DATA.

Reset asserted mid-burst: the block returns to IDLE immediately and drops any outstanding beats. The system resets the interconnect together with this block.

Simultaneous events: if all requesters assert `arvalid` in the same IDLE cycle, exactly one bit of `req_arready` is set.

## Test plan
- Single request: requester 2, addr 0x1000, arlen 3; core returns 4 beats with `rlast` on beat 4. Required: `m_axi_core_araddr=0x1000`, `arlen=3`; `req_rvalid=4'b0100` on each beat; `len_err=0`; IDLE one cycle after `rlast`.
- Fairness: all 4 requesters hold `arvalid` continuously, arlen 0. Required grant order is 0,1,2,3,0 and every requester is served within 4 bursts.
- Backpressure: `req_rready` toggles 1,0,1,0 during an 8-beat burst. Required: `m_axi_core_rready` mirrors it, no beat is lost, and the beat count reaches 8.
- Length error: arlen 3, core asserts `rlast` on beat 2. Required: `len_err=1` stays set through subsequent good bursts, and the FSM returns to IDLE.
- Stall in ADDR: `m_axi_core_arready` held low for 10 cycles. Required: `arvalid`, `araddr` and `arlen` stay stable, and a new `req_arvalid` from another requester gets no `req_arready`.
- Reset mid-burst: `rst_n` driven low during beat 2 of 4. Required: outputs return to reset values immediately; after release, requester 0 is granted first.
